// File: rtl/magnetron_control.sv
// Microwave oven control FSM. Turns keypad digits, start/stop buttons and the
// door interlock into load/clear/enable strobes for the countdown timer, and
// drives the magnetron and the completion beeper.
module magnetron_control #(
  parameter int BEEP_CYCLES = 3,
  parameter int MAX_DIGITS  = 3
) (
  input  logic       CLK,
  input  logic       clearn,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  input  logic       timer_done,
  output logic [3:0] timer_digit,
  output logic       timer_loadn,
  output logic       timer_clearn,
  output logic       timer_enable,
  output logic       mag_on,
  output logic       beep,
  output logic [1:0] state_o
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COOKING = 2'd1,
    PAUSED  = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic [3:0]       beep_cnt, beep_cnt_n;
  logic [3:0]       digit_n;
  logic             loadn_n, clrn_n, beep_n;
  logic             start_q, stop_q;
  logic             start_ev, stop_ev;
  logic             run;

  // Falling-edge detection on the buttons; stop wins a simultaneous press.
  assign stop_ev  = stop_q & ~stopn;
  assign start_ev = start_q & ~startn & ~stop_ev;

  // Magnetron and timer enable drop combinationally on door open or 0:00.
  assign run          = (state == COOKING) & door_closed & ~timer_done;
  assign mag_on       = run;
  assign timer_enable = run;
  assign state_o      = state;

  // Next-state and registered-output decode.
  always_comb begin
    state_n    = state;
    count_n    = count;
    beep_cnt_n = beep_cnt;
    digit_n    = timer_digit;
    loadn_n    = 1'b1;
    clrn_n     = 1'b1;
    beep_n     = 1'b0;
    case (state)
      IDLE: begin
        if (stop_ev) begin
          clrn_n  = 1'b0;
          count_n = '0;
        end else begin
          // Digits shift into the timer only while there is room for them.
          if (key_valid && (key_digit <= 4'd9) && (count < CNT_W'(MAX_DIGITS))) begin
            digit_n = key_digit;
            loadn_n = 1'b0;
            count_n = count + CNT_W'(1);
          end
          if (start_ev && door_closed && !timer_done) begin
            state_n = COOKING;
          end
        end
      end
      COOKING: begin
        if (timer_done) begin
          state_n    = DONE;
          beep_cnt_n = 4'(BEEP_CYCLES);
          beep_n     = 1'b1;
        end else if (stop_ev || !door_closed) begin
          state_n = PAUSED;
        end
      end
      PAUSED: begin
        if (stop_ev) begin
          state_n = IDLE;
          clrn_n  = 1'b0;
          count_n = '0;
        end else if (start_ev && door_closed && !timer_done) begin
          state_n = COOKING;
        end
      end
      DONE: begin
        if (stop_ev) begin
          state_n    = IDLE;
          beep_cnt_n = '0;
        end else if (beep_cnt <= 4'd1) begin
          // Last beep cycle: counter hits zero on this edge.
          state_n    = IDLE;
          beep_cnt_n = '0;
          count_n    = '0;
        end else begin
          beep_cnt_n = beep_cnt - 4'd1;
          beep_n     = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs; reset also clears the downstream timer.
  always_ff @(posedge CLK) begin
    if (!clearn) begin
      state        <= IDLE;
      count        <= '0;
      beep_cnt     <= '0;
      start_q      <= 1'b1;
      stop_q       <= 1'b1;
      timer_digit  <= 4'd0;
      timer_loadn  <= 1'b1;
      timer_clearn <= 1'b0;
      beep         <= 1'b0;
    end else begin
      state        <= state_n;
      count        <= count_n;
      beep_cnt     <= beep_cnt_n;
      start_q      <= startn;
      stop_q       <= stopn;
      timer_digit  <= digit_n;
      timer_loadn  <= loadn_n;
      timer_clearn <= clrn_n;
      beep         <= beep_n;
    end
  end

endmodule

// File: tb/tb_magnetron_control.sv
// Scoreboarded bench for magnetron_control: directed scenarios followed by
// random button/door/keypad traffic against a behavioural oven model.
module tb_magnetron_control;

  localparam int BEEP = 3;
  localparam int MAXD = 3;

  logic       CLK = 1'b0;
  logic       clearn = 1'b0, key_valid = 1'b0, startn = 1'b1, stopn = 1'b1;
  logic       door_closed = 1'b1, timer_done = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic [3:0] timer_digit;
  logic       timer_loadn, timer_clearn, timer_enable, mag_on, beep;
  logic [1:0] state_o;

  magnetron_control #(.BEEP_CYCLES(BEEP), .MAX_DIGITS(MAXD)) dut (
    .CLK(CLK), .clearn(clearn), .key_valid(key_valid), .key_digit(key_digit),
    .startn(startn), .stopn(stopn), .door_closed(door_closed),
    .timer_done(timer_done), .timer_digit(timer_digit),
    .timer_loadn(timer_loadn), .timer_clearn(timer_clearn),
    .timer_enable(timer_enable), .mag_on(mag_on), .beep(beep),
    .state_o(state_o)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         st;
    logic       mag;
    logic       loadn;
    logic       clrn;
    logic [3:0] dig;
    logic       bp;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Stimulus for the next cycle
  logic       nx_clearn = 1'b0, nx_kv = 1'b0, nx_startn = 1'b1, nx_stopn = 1'b1;
  logic       nx_door = 1'b1, nx_done = 1'b0;
  logic [3:0] nx_kd = 4'd0;

  // Behavioural oven: mode name, digits entered so far, time spent beeping
  int         m_mode = 0;       // 0 idle, 1 cooking, 2 paused, 3 done
  int         m_digits[$];
  int         m_done_age = 0;
  logic       m_start_prev = 1'b1, m_stop_prev = 1'b1;
  logic [3:0] m_shown = 4'd0;
  logic       m_load = 1'b0, m_clear = 1'b0;

  task automatic model_edge();
    bit press_start, press_stop, can_cook;
    m_load  = 1'b0;
    m_clear = 1'b0;
    if (!clearn) begin
      m_mode = 0; m_digits.delete(); m_done_age = 0;
      m_start_prev = 1'b1; m_stop_prev = 1'b1;
      m_shown = 4'd0; m_clear = 1'b1;
      return;
    end
    press_stop  = m_stop_prev && !stopn;
    press_start = m_start_prev && !startn && !press_stop;
    m_start_prev = startn;
    m_stop_prev  = stopn;
    can_cook = press_start && door_closed && !timer_done;
    if (m_mode == 0) begin
      if (press_stop) begin
        m_clear = 1'b1; m_digits.delete();
      end else begin
        if (key_valid && key_digit < 10 && m_digits.size() < MAXD) begin
          m_digits.push_back(int'(key_digit));
          m_shown = key_digit; m_load = 1'b1;
        end
        if (can_cook) m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (timer_done) begin
        m_mode = 3; m_done_age = 0;
      end else if (press_stop || !door_closed) m_mode = 2;
    end else if (m_mode == 2) begin
      if (press_stop) begin
        m_mode = 0; m_clear = 1'b1; m_digits.delete();
      end else if (can_cook) m_mode = 1;
    end else begin
      if (press_stop) m_mode = 0;
      else begin
        m_done_age++;
        if (m_done_age >= BEEP) begin
          m_mode = 0; m_digits.delete();
        end
      end
    end
  endtask

  task automatic tick(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      model_edge();
      #2;
      clearn = nx_clearn; key_valid = nx_kv; key_digit = nx_kd;
      startn = nx_startn; stopn = nx_stopn;
      door_closed = nx_door; timer_done = nx_done;
      e.st    = m_mode;
      e.mag   = (m_mode == 1) && door_closed && !timer_done;
      e.loadn = !m_load;
      e.clrn  = !m_clear;
      e.dig   = m_shown;
      e.bp    = (m_mode == 3);
      q.push_back(e);
    end
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: pops one expectation per cycle and compares mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("state_o", {2'b00, state_o}, 4'(e.st));
        chk("mag_on", {3'b000, mag_on}, {3'b000, e.mag});
        chk("timer_enable", {3'b000, timer_enable}, {3'b000, e.mag});
        chk("timer_loadn", {3'b000, timer_loadn}, {3'b000, e.loadn});
        chk("timer_clearn", {3'b000, timer_clearn}, {3'b000, e.clrn});
        chk("timer_digit", timer_digit, e.dig);
        chk("beep", {3'b000, beep}, {3'b000, e.bp});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic key(input logic [3:0] d);
    nx_kv = 1'b1; nx_kd = d; tick(1);
    nx_kv = 1'b0; tick(1);
  endtask

  task automatic press_start();
    nx_startn = 1'b0; tick(1);
    nx_startn = 1'b1; tick(1);
  endtask

  initial begin
    // Reset, then three digits and one surplus digit
    nx_clearn = 1'b0; tick(2);
    nx_clearn = 1'b1; tick(1);
    key(4'd1); key(4'd3); key(4'd0); key(4'd5); key(4'd12);
    // Start held for ten cycles: one event only
    nx_startn = 1'b0; tick(10);
    nx_startn = 1'b1; tick(2);
    // Door opens while cooking, then closes and restarts
    nx_door = 1'b0; tick(3);
    nx_door = 1'b1; tick(1);
    press_start(); tick(2);
    // Timer reaches zero: DONE and beep, then back to IDLE
    nx_done = 1'b1; tick(6);
    nx_done = 1'b0; tick(1);
    // Cook, pause by stop, then start+stop together in PAUSED
    key(4'd7); press_start(); tick(1);
    nx_stopn = 1'b0; tick(1);
    nx_stopn = 1'b1; tick(1);
    nx_startn = 1'b0; nx_stopn = 1'b0; tick(1);
    nx_startn = 1'b1; nx_stopn = 1'b1; tick(2);
    // Zero time entered: start ignored
    nx_done = 1'b1; tick(1);
    press_start(); tick(1);
    nx_done = 1'b0; tick(1);
    // Reset in the middle of cooking
    key(4'd9); press_start(); tick(2);
    nx_clearn = 1'b0; tick(1);
    nx_clearn = 1'b1; tick(2);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      nx_clearn = ($urandom_range(0, 199) != 0);
      nx_kv     = ($urandom_range(0, 3) == 0);
      nx_kd     = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) nx_startn = ~nx_startn;
      if ($urandom_range(0, 9) == 0) nx_stopn = ~nx_stopn;
      nx_door   = ($urandom_range(0, 9) != 0);
      nx_done   = ($urandom_range(0, 7) == 0);
      tick(1);
    end
    @(negedge CLK);
    @(negedge CLK);
    #1;
    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
